int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller_pkg.sv | 23 ++
 rtl/int_prio_enc.sv | 28 ++
 rtl/int_controller.sv | 157 +++++++++++++++
 tb/tb_int_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register-select codes and STATUS word bit positions.
package int_controller_pkg;

  // Controller FSM state, binary encoded. The two-bit value is also what
  // software sees in the STATUS register.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // reg_sel codes
  localparam logic [1:0] SEL_MASK    = 2'd0;
  localparam logic [1:0] SEL_PENDING = 2'd1;
  localparam logic [1:0] SEL_VECTOR  = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  // STATUS word layout: bit 0 = int_req, bits [2:1] = FSM state
  localparam int STATUS_REQ_BIT   = 0;
  localparam int STATUS_STATE_LSB = 1;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
// Ports:
//   eligible : N-bit request vector
//   valid    : 1 when any eligible bit is set
//   idx      : index of the lowest set bit, zero-extended to IDX_W
//              (0 when valid is 0)
module int_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 16
) (
  input  logic [N-1:0]     eligible,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Edge-triggered interrupt controller with mask/pending registers, a
// lowest-index-wins arbiter and a request/acknowledge/done handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   irq_src[NUM_SRC]    : synchronous active-high device lines (rising edge = event)
//   read, write         : register access strobes
//   reg_sel[2]          : 0 MASK, 1 PENDING, 2 VECTOR, 3 STATUS
//   in_bus[VEC_W]       : write data
//   out_bus[VEC_W]      : registered read data, holds between reads
//   int_req             : request to CPU, high exactly while in REQ
//   int_ack, int_done   : CPU accept / return-from-interrupt pulses
//   int_addr[VEC_W]     : vector latched at acknowledge (source index)
//
// Handshake: int_req is raised once an unmasked pending source exists and
// stays high until either int_ack is seen (request taken, the winning source
// index is latched into int_addr and its PENDING bit cleared on that edge)
// or the request evaporates because every eligible source was masked or
// cleared. After int_ack the controller waits for int_done before it may
// request again; there is no nesting, so stray int_ack/int_done pulses
// outside their states are ignored.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int VEC_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               read,
  input  logic               write,
  input  logic [1:0]         reg_sel,
  input  logic [VEC_W-1:0]   in_bus,
  output logic [VEC_W-1:0]   out_bus,
  output logic               int_req,
  input  logic               int_ack,
  input  logic               int_done,
  output logic [VEC_W-1:0]   int_addr
);

  state_t             state_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] prev_q;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] wr_clr;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pend_d;
  logic               win_valid;
  logic [VEC_W-1:0]   win_idx;
  logic               take_ack;
  logic [VEC_W-1:0]   rd_data;

  assign edges    = irq_src & ~prev_q;
  assign eligible = pend_q & ~mask_q;

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (VEC_W)
  ) u_prio_enc (
    .eligible (eligible),
    .valid    (win_valid),
    .idx      (win_idx)
  );

  // An acknowledge only counts in REQ while a winner still exists.
  assign take_ack = (state_q == ST_REQ) && int_ack && win_valid;

  // PENDING update: clears (software W1C and the acknowledged winner) are
  // applied first, then fresh edges are OR-ed in so a new event on the same
  // bit is never lost.
  always_comb begin
    wr_clr  = '0;
    ack_clr = '0;
    if (write && (reg_sel == SEL_PENDING)) begin
      wr_clr = in_bus[NUM_SRC-1:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = take_ack && (win_idx == VEC_W'(i));
    end
    pend_d = (pend_q & ~(wr_clr | ack_clr)) | edges;
  end

  // Read mux; narrower registers are zero-extended.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      SEL_MASK:    rd_data[NUM_SRC-1:0] = mask_q;
      SEL_PENDING: rd_data[NUM_SRC-1:0] = pend_q;
      SEL_VECTOR:  rd_data = int_addr;
      default: begin
        rd_data[STATUS_STATE_LSB +: 2] = state_q;
        rd_data[STATUS_REQ_BIT]        = int_req;
      end
    endcase
  end

  // Register file and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '1;
      pend_q  <= '0;
      prev_q  <= '0;
      out_bus <= '0;
    end else begin
      prev_q <= irq_src;
      pend_q <= pend_d;
      if (write && (reg_sel == SEL_MASK)) begin
        mask_q <= in_bus[NUM_SRC-1:0];
      end
      if (read) begin
        out_bus <= rd_data;
      end
    end
  end

  // Controller FSM; int_req is registered alongside the state so it is high
  // exactly while the state is REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      int_req  <= 1'b0;
      int_addr <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q <= ST_REQ;
            int_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (take_ack) begin
            state_q  <= ST_SERVICE;
            int_req  <= 1'b0;
            int_addr <= win_idx;
          end else if (!win_valid) begin
            state_q <= ST_IDLE;
            int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, all
// checked against a transaction-level reference model through a queue.
module tb_int_controller;
  import int_controller_pkg::*;

  localparam int NS = 16;
  localparam int VW = 16;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] irq_src;
  logic          read;
  logic          write;
  logic [1:0]    reg_sel;
  logic [VW-1:0] in_bus;
  logic [VW-1:0] out_bus;
  logic          int_req;
  logic          int_ack;
  logic          int_done;
  logic [VW-1:0] int_addr;

  int_controller #(.NUM_SRC(NS), .VEC_W(VW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .read     (read),
    .write    (write),
    .reg_sel  (reg_sel),
    .in_bus   (in_bus),
    .out_bus  (out_bus),
    .int_req  (int_req),
    .int_ack  (int_ack),
    .int_done (int_done),
    .int_addr (int_addr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_mask, m_pend, m_prev, m_addr;
  state_t      m_state;
  logic        m_req;

  // expected entry: {check_out, int_req, int_addr, out_bus}
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_mask  = 16'hFFFF;
    m_pend  = 16'h0;
    m_prev  = 16'h0;
    m_addr  = 16'h0;
    m_state = ST_IDLE;
    m_req   = 1'b0;
  endtask

  // One clock of stimulus. The model applies the rules to the values seen
  // at this edge and queues what the DUT must show afterwards.
  task automatic step(input logic [15:0] src, input logic rd, input logic wr,
                      input logic [1:0] sel, input logic [15:0] din,
                      input logic ack, input logic done);
    logic [15:0] edges, elig, new_pend, rd_val;
    int win;
    irq_src = src; read = rd; write = wr; reg_sel = sel; in_bus = din;
    int_ack = ack; int_done = done;

    edges = src & ~m_prev;
    elig  = m_pend & ~m_mask;
    win   = -1;
    for (int i = 0; i < 16; i++) if (elig[i] && win < 0) win = i;

    case (sel)
      2'd0:    rd_val = m_mask;
      2'd1:    rd_val = m_pend;
      2'd2:    rd_val = m_addr;
      default: rd_val = {13'b0, m_state, m_req};
    endcase

    new_pend = m_pend;
    if (wr && sel == 2'd1) new_pend = new_pend & ~din;
    case (m_state)
      ST_IDLE: if (elig != 0) m_state = ST_REQ;
      ST_REQ: begin
        if (ack && win >= 0) begin
          m_state = ST_SERVICE;
          m_addr  = 16'(win);
          new_pend[win] = 1'b0;
        end else if (elig == 0) m_state = ST_IDLE;
      end
      default: if (done) m_state = ST_IDLE;
    endcase
    m_pend = new_pend | edges;
    if (wr && sel == 2'd0) m_mask = din;
    m_req  = (m_state == ST_REQ);
    m_prev = src;

    @(posedge clk);
    exp_q.push_back({rd, m_req, m_addr, rd_val});
    @(negedge clk);
  endtask

  task automatic nop();                                     step(16'h0, 0, 0, 2'd0, 16'h0, 0, 0); endtask
  task automatic wr_reg(input logic [1:0] s, input logic [15:0] d); step(16'h0, 0, 1, s, d, 0, 0); endtask
  task automatic rd_reg(input logic [1:0] s);               step(16'h0, 1, 0, s, 16'h0, 0, 0); endtask
  task automatic pulse(input logic [15:0] src);             step(src, 0, 0, 2'd0, 16'h0, 0, 0); endtask
  task automatic ack();                                     step(16'h0, 0, 0, 2'd0, 16'h0, 1, 0); endtask
  task automatic done();                                    step(16'h0, 0, 0, 2'd0, 16'h0, 0, 1); endtask

  // Asynchronous reset applied between clock edges; outputs are checked
  // before any further clock edge arrives.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    irq_src = '0; read = 0; write = 0; reg_sel = '0; in_bus = '0;
    int_ack = 0; int_done = 0;
    #1;
    check("rst_int_req", {15'b0, int_req}, 16'h0);
    check("rst_int_addr", int_addr, 16'h0);
    check("rst_out_bus", out_bus, 16'h0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("int_req", {15'b0, int_req}, {15'b0, e[32]});
      check("int_addr", int_addr, e[31:16]);
      if (e[33]) check("out_bus", out_bus, e[15:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    irq_src = '0; read = 0; write = 0; reg_sel = '0; in_bus = '0;
    int_ack = 0; int_done = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    rd_reg(SEL_MASK);
    rd_reg(SEL_STATUS);

    // single source request / ack
    wr_reg(SEL_MASK, 16'h0000);
    pulse(16'h0004);
    nop();
    nop();
    ack();
    rd_reg(SEL_PENDING);
    rd_reg(SEL_VECTOR);
    rd_reg(SEL_STATUS);
    done();
    nop();

    // two sources in one cycle: lowest wins, other waits its turn
    pulse(16'h0022);
    nop();
    ack();
    nop();
    pulse(16'h0001);           // lower edge while servicing bit 1
    rd_reg(SEL_PENDING);
    done();
    nop();
    ack();                     // bit 0 now wins
    done();
    nop();
    ack();                     // then bit 5
    rd_reg(SEL_VECTOR);
    done();
    nop();

    // masked source stays pending, unmasking releases it
    wr_reg(SEL_MASK, 16'hFFFF);
    pulse(16'h0008);
    nop();
    rd_reg(SEL_PENDING);
    rd_reg(SEL_STATUS);
    wr_reg(SEL_MASK, 16'hFFF7);
    nop();
    nop();
    ack();
    done();

    // request withdrawn by masking before ack
    wr_reg(SEL_MASK, 16'h0000);
    pulse(16'h0040);
    nop();
    nop();
    wr_reg(SEL_MASK, 16'hFFFF);
    nop();
    ack();                     // ignored: no longer in REQ
    rd_reg(SEL_STATUS);
    rd_reg(SEL_PENDING);
    done();                    // ignored in IDLE
    wr_reg(SEL_PENDING, 16'hFFFF);
    rd_reg(SEL_PENDING);

    // edge and W1C on the same bit in one cycle: set wins
    step(16'h0010, 0, 1, SEL_PENDING, 16'h0010, 0, 0);
    rd_reg(SEL_PENDING);
    wr_reg(SEL_VECTOR, 16'h1234);
    wr_reg(SEL_STATUS, 16'hFFFF);
    rd_reg(SEL_PENDING);
    rd_reg(SEL_VECTOR);
    wr_reg(SEL_PENDING, 16'h0010);

    // ack and done together in REQ: ack wins
    wr_reg(SEL_MASK, 16'h0000);
    pulse(16'h0100);
    nop();
    step(16'h0, 0, 0, 2'd0, 16'h0, 1, 1);
    rd_reg(SEL_STATUS);
    done();

    // reset during SERVICE
    pulse(16'h0080);
    nop();
    ack();
    rd_reg(SEL_VECTOR);
    do_reset();
    rd_reg(SEL_MASK);
    rd_reg(SEL_PENDING);
    rd_reg(SEL_STATUS);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] src, din;
      logic [1:0]  sel;
      if (n == 1500) do_reset();
      src = 16'($urandom) & 16'($urandom) & 16'($urandom);
      sel = 2'($urandom_range(0, 3));
      din = (sel == 2'd0) ? (16'($urandom) | 16'($urandom)) : 16'($urandom);
      step(src, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), sel, din,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    nop();
    nop();
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
